// File: rtl/adder_share_arbiter.sv
// prefix_adder: Kogge-Stone adder, sum plus carry-out.
// Latency: combinational.
// Backpressure: none; pure datapath.
module prefix_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum_stage,
   output logic             carry_bka
);
   localparam int LVLS = $clog2(WIDTH);

   logic [WIDTH-1:0] g [LVLS+1];
   logic [WIDTH-1:0] p [LVLS+1];

   // Level l combines each bit's (g,p) with the pair 2^l positions below it.
   always_comb begin
      g[0] = a & b;
      p[0] = a ^ b;
      for (int l = 0; l < LVLS; l++) begin
         g[l+1] = g[l];
         p[l+1] = p[l];
         for (int i = (1 << l); i < WIDTH; i++) begin
            g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1 << l)]);
            p[l+1][i] = p[l][i] & p[l][i-(1 << l)];
         end
      end
   end

   assign sum_stage = p[0] ^ {g[LVLS][WIDTH-2:0], 1'b0};
   assign carry_bka = g[LVLS][WIDTH-1];
endmodule

// adder_share_arbiter: round-robin share of one prefix_adder across NUM_REQ requesters.
// Latency: 1 cycle from accept to rsp_valid; 1 result per cycle while drained.
// Backpressure: single-entry response slot; all req_ready low while slot full and undrained.
module adder_share_arbiter #(
   parameter int ADDER_WIDTH = 32,
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_operand_a,
   input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_operand_b,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [ADDER_WIDTH:0]           rsp_sum,
   output logic [ID_W-1:0]                rsp_id,
   output logic [15:0]                    stall_count
);
   typedef enum logic {EMPTY, FULL} slot_state_t;

   localparam logic [ID_W:0]   NUM_REQ_L = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

   slot_state_t            state, state_nxt;
   logic [ID_W-1:0]        rr_ptr;
   logic [ID_W-1:0]        winner;
   logic                   win_vld;
   logic [ID_W:0]          scan_idx;
   logic                   slot_free;
   logic                   accept;
   logic [ADDER_WIDTH-1:0] op_a, op_b;
   logic [ADDER_WIDTH-1:0] sum_stage;
   logic                   carry_bka;

   assign rsp_valid = (state == FULL);
   assign slot_free = !rsp_valid || rsp_ready;
   assign accept    = rst_n && slot_free && win_vld;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      winner   = '0;
      win_vld  = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (scan_idx >= NUM_REQ_L)
            scan_idx = scan_idx - NUM_REQ_L;
         if (!win_vld && req_valid[scan_idx[ID_W-1:0]]) begin
            winner  = scan_idx[ID_W-1:0];
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (accept)
         req_ready[winner] = 1'b1;
   end

   assign op_a = req_operand_a[int'(winner)*ADDER_WIDTH +: ADDER_WIDTH];
   assign op_b = req_operand_b[int'(winner)*ADDER_WIDTH +: ADDER_WIDTH];

   prefix_adder #(.WIDTH(ADDER_WIDTH)) u_adder (
      .a         (op_a),
      .b         (op_b),
      .sum_stage (sum_stage),
      .carry_bka (carry_bka)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (accept) state_nxt = FULL;
         FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= EMPTY;
         rsp_sum     <= '0;
         rsp_id      <= '0;
         rr_ptr      <= '0;
         stall_count <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            rsp_sum <= {carry_bka, sum_stage};
            rsp_id  <= winner;
            rr_ptr  <= (winner == LAST_ID) ? '0 : winner + 1'b1;
         end
         if (rsp_valid && !rsp_ready && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed scenarios plus a queue-based scoreboard with an independent round-robin model.
module tb_adder_share_arbiter;
   localparam int W      = 32;
   localparam int N      = 4;
   localparam int IDW    = 2;
   localparam int NRAND  = 10000;
   localparam int BUDGET = 60000;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*W-1:0]     req_operand_a;
   logic [N*W-1:0]     req_operand_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [W:0]         rsp_sum;
   logic [IDW-1:0]     rsp_id;
   logic [15:0]        stall_count;

   typedef struct {
      logic [IDW-1:0] id;
      logic [W:0]     sum;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   adder_share_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_operand_a (req_operand_a),
      .req_operand_b (req_operand_b),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_sum       (rsp_sum),
      .rsp_id        (rsp_id),
      .stall_count   (stall_count)
   );

   task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_operand_a[i*W +: W] = a;
      req_operand_b[i*W +: W] = b;
   endtask

   task automatic reset_dut();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      req_valid     = '1;
      rsp_ready     = 1'b1;
      req_operand_a = '1;
      req_operand_b = '1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0000", req_ready);
         else n_pass++;
         n_checks++;
         if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
         else n_pass++;
         n_checks++;
         if (rsp_sum !== '0) $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum);
         else n_pass++;
         n_checks++;
         if (stall_count !== 16'd0) $display("FAIL reset_stall: got %0d want 0", stall_count);
         else n_pass++;
      end
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = '0;
   endtask

   task automatic test_carry_out();
      set_ops(2, 32'hFFFF_FFFF, 32'h0000_0001);
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0100) $display("FAIL carry_grant: got %b want 0100", req_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1) $display("FAIL carry_rsp_valid: got %b want 1", rsp_valid);
      else n_pass++;
      n_checks++;
      if (rsp_sum !== 33'h1_0000_0000) $display("FAIL carry_sum: got %h want 100000000", rsp_sum);
      else n_pass++;
      n_checks++;
      if (rsp_id !== 2'd2) $display("FAIL carry_id: got %0d want 2", rsp_id);
      else n_pass++;
      n_checks++;
      if (req_ready !== 4'b0000) $display("FAIL carry_grant_once: got %b want 0000", req_ready);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_round_robin();
      exp_t e;
      logic [N-1:0] exp_rdy;
      reset_dut();
      sb.delete();
      for (int i = 0; i < N; i++) set_ops(i, W'(i), 32'd100);
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_sum !== e.sum)
               $display("FAIL rr_rsp[%0d]: got v=%b id=%0d sum=%0d want v=1 id=%0d sum=%0d",
                        k, rsp_valid, rsp_id, rsp_sum, e.id, e.sum);
            else n_pass++;
         end
         exp_rdy = '0;
         exp_rdy[k % N] = 1'b1;
         n_checks++;
         if (req_ready !== exp_rdy) $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy);
         else n_pass++;
         e.id  = IDW'(k % N);
         e.sum = (W+1)'(100 + (k % N));
         sb.push_back(e);
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      sb.delete();
   endtask

   task automatic test_backpressure();
      reset_dut();
      set_ops(0, 32'd10, 32'd20);
      set_ops(1, 32'd30, 32'd40);
      req_valid = 4'b0011;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (req_ready !== 4'b0000) $display("FAIL bp_grant[%0d]: got %b want 0000", k, req_ready);
         else n_pass++;
         n_checks++;
         if (rsp_id !== 2'd0 || rsp_sum !== 33'd30)
            $display("FAIL bp_hold[%0d]: got id=%0d sum=%0d want id=0 sum=30", k, rsp_id, rsp_sum);
         else n_pass++;
         n_checks++;
         if (stall_count !== 16'(k)) $display("FAIL bp_stall[%0d]: got %0d want %0d", k, stall_count, k);
         else n_pass++;
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (stall_count !== 16'd5) $display("FAIL bp_stall_total: got %0d want 5", stall_count);
      else n_pass++;
      n_checks++;
      if (req_ready !== 4'b0010) $display("FAIL bp_next_grant: got %b want 0010", req_ready);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 33'd70)
         $display("FAIL mid_full: got v=%b id=%0d sum=%0d want v=1 id=1 sum=70", rsp_valid, rsp_id, rsp_sum);
      else n_pass++;
      n_checks++;
      if (req_ready !== 4'b0000) $display("FAIL mid_rst_grant: got %b want 0000", req_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid);
      else n_pass++;
      n_checks++;
      if (stall_count !== 16'd0) $display("FAIL mid_stall: got %0d want 0", stall_count);
      else n_pass++;
      n_checks++;
      if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", req_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 33'd30)
         $display("FAIL mid_after: got v=%b id=%0d sum=%0d want v=1 id=0 sum=30", rsp_valid, rsp_id, rsp_sum);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [N-1:0] cur_vld = '0;
      logic [W-1:0] ca [N];
      logic [W-1:0] cb [N];
      logic [N-1:0] exp_rdy;
      logic [15:0]  stall_m = '0;
      logic         full;
      exp_t         e;
      int           rr = 0, drained = 0, generated = 0, cyc = 0, win, idx;
      reset_dut();
      sb.delete();
      while (drained < NRAND && cyc < BUDGET) begin
         for (int i = 0; i < N; i++) begin
            if (!cur_vld[i] && generated < NRAND && $urandom_range(0, 1) == 1) begin
               cur_vld[i] = 1'b1;
               ca[i] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom());
               cb[i] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom());
               generated++;
            end
            set_ops(i, ca[i], cb[i]);
         end
         req_valid = cur_vld;
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         full = (sb.size() != 0);
         n_checks++;
         if (rsp_valid !== full) $display("FAIL rnd_rsp_valid@%0d: got %b want %b", cyc, rsp_valid, full);
         else n_pass++;
         n_checks++;
         if (stall_count !== stall_m) $display("FAIL rnd_stall@%0d: got %0d want %0d", cyc, stall_count, stall_m);
         else n_pass++;
         win = -1;
         for (int k = 0; k < N; k++) begin
            idx = (rr + k) % N;
            if (win < 0 && cur_vld[idx]) win = idx;
         end
         exp_rdy = '0;
         if (win >= 0 && (!full || rsp_ready)) exp_rdy[win] = 1'b1;
         n_checks++;
         if (req_ready !== exp_rdy) $display("FAIL rnd_grant@%0d: got %b want %b", cyc, req_ready, exp_rdy);
         else n_pass++;
         if (full && rsp_ready) begin
            e = sb.pop_front();
            n_checks++;
            if (rsp_id !== e.id || rsp_sum !== e.sum)
               $display("FAIL rnd_rsp@%0d: got id=%0d sum=%h want id=%0d sum=%h", cyc, rsp_id, rsp_sum, e.id, e.sum);
            else n_pass++;
            drained++;
         end
         if (full && !rsp_ready && stall_m != 16'hFFFF) stall_m++;
         if (exp_rdy != '0) begin
            e.id  = IDW'(win);
            e.sum = {1'b0, ca[win]} + {1'b0, cb[win]};
            sb.push_back(e);
            cur_vld[win] = 1'b0;
            rr = (win + 1) % N;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      req_valid = '0;
      n_checks++;
      if (drained != NRAND) $display("FAIL rnd_drained: got %0d want %0d", drained, NRAND);
      else n_pass++;
      n_checks++;
      if (sb.size() != 0) $display("FAIL rnd_leftover: got %0d want 0", sb.size());
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL rnd_no_dup: got rsp_valid=%b want 0", rsp_valid);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_carry_out();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
